// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcode encoding of the external alu
// and the sequencer state enumeration.
package alu_pkg;

  // Opcode encoding, identical to the external alu's ALU_Sel input.
  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpMul  = 4'b0010;
  localparam logic [3:0] OpDiv  = 4'b0011;
  localparam logic [3:0] OpShl  = 4'b0100;
  localparam logic [3:0] OpShr  = 4'b0101;
  localparam logic [3:0] OpRol  = 4'b0110;
  localparam logic [3:0] OpRor  = 4'b0111;
  localparam logic [3:0] OpAnd  = 4'b1000;
  localparam logic [3:0] OpOr   = 4'b1001;
  localparam logic [3:0] OpXor  = 4'b1010;
  localparam logic [3:0] OpNor  = 4'b1011;
  localparam logic [3:0] OpNand = 4'b1100;
  localparam logic [3:0] OpXnor = 4'b1101;
  localparam logic [3:0] OpGt   = 4'b1110;
  localparam logic [3:0] OpEq   = 4'b1111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  // A response closes its command when it is a single-op command, or when a
  // sweep has reached the final opcode.
  function automatic logic is_last_rsp(input logic sweep, input logic [3:0] op);
    return !sweep || (op == OpEq);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Drives an external combinational alu: accepts a single-op or 16-op sweep
// command, issues each opcode, captures the result and hands it out over a
// valid/ready response channel, one response per opcode.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter logic [7:0] DIV0_VAL = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  // Command channel
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_sweep,
  // External alu
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  // Response channel
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_op,
  output logic       rsp_carry,
  output logic       rsp_dz,
  output logic       rsp_last
);

  state_e     state_q;
  logic       sweep_q;
  logic       cmd_ready_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [3:0] alu_sel_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic [3:0] rsp_op_q;
  logic       rsp_carry_q;
  logic       rsp_dz_q;
  logic       rsp_last_q;

  // Divide-by-zero is judged on the latched operand, not on the alu result.
  logic div_zero;
  assign div_zero = (alu_sel_q == OpDiv) && (alu_b_q == 8'd0);

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sweep_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      alu_a_q     <= 8'd0;
      alu_b_q     <= 8'd0;
      alu_sel_q   <= OpAdd;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      rsp_op_q    <= OpAdd;
      rsp_carry_q <= 1'b0;
      rsp_dz_q    <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid && cmd_ready_q) begin
            alu_a_q     <= cmd_a;
            alu_b_q     <= cmd_b;
            alu_sel_q   <= cmd_sweep ? OpAdd : cmd_op;
            sweep_q     <= cmd_sweep;
            cmd_ready_q <= 1'b0;
            state_q     <= StExec;
          end
        end
        StExec: begin
          // alu_sel has been stable for a full cycle, so alu_out is settled.
          rsp_valid_q <= 1'b1;
          rsp_op_q    <= alu_sel_q;
          rsp_data_q  <= div_zero ? DIV0_VAL : alu_out;
          rsp_dz_q    <= div_zero;
          rsp_carry_q <= (alu_sel_q == OpAdd) && alu_carry;
          rsp_last_q  <= is_last_rsp(sweep_q, alu_sel_q);
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (rsp_last_q) begin
              cmd_ready_q <= 1'b1;
              state_q     <= StIdle;
            end else begin
              // Not last implies a sweep below OpEq, so this never wraps.
              alu_sel_q <= alu_sel_q + 4'd1;
              state_q   <= StExec;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_dz    = rsp_dz_q;
  assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural alu beside it.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_sweep;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_op;
  logic       rsp_carry;
  logic       rsp_dz;
  logic       rsp_last;

  alu_sequencer #(.DIV0_VAL(8'hFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sweep (cmd_sweep),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_op    (rsp_op),
    .rsp_carry (rsp_carry),
    .rsp_dz    (rsp_dz),
    .rsp_last  (rsp_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] data;
    logic [3:0] op;
    logic       carry;
    logic       dz;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   resp_idx = 0;
  int   stall_cnt = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: stall third response 5 cycles

  // Behaviour of the external alu; divide by zero deliberately returns 0 so
  // the sequencer's own substitution is what gets observed.
  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      OpAdd:   return a + b;
      OpSub:   return a - b;
      OpMul:   return a * b;
      OpDiv:   return (b == 8'd0) ? 8'd0 : a / b;
      OpShl:   return a << 1;
      OpShr:   return a >> 1;
      OpRol:   return {a[6:0], a[7]};
      OpRor:   return {a[0], a[7:1]};
      OpAnd:   return a & b;
      OpOr:    return a | b;
      OpXor:   return a ^ b;
      OpNor:   return ~(a | b);
      OpNand:  return ~(a & b);
      OpXnor:  return ~(a ^ b);
      OpGt:    return {7'd0, a > b};
      OpEq:    return {7'd0, a == b};
      default: return 8'd0;
    endcase
  endfunction

  always_comb begin
    logic [8:0] sum;
    sum       = {1'b0, alu_a} + {1'b0, alu_b};
    alu_out   = alu_fn(alu_sel, alu_a, alu_b);
    alu_carry = sum[8];
  end

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] op, input logic last);
    exp_t e;
    logic [8:0] sum;
    sum     = {1'b0, a} + {1'b0, b};
    e.a     = a;
    e.b     = b;
    e.op    = op;
    e.last  = last;
    e.dz    = (op == OpDiv) && (b == 8'd0);
    e.data  = e.dz ? 8'hFF : alu_fn(op, a, b);
    e.carry = (op == OpAdd) ? sum[8] : 1'b0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                              input logic [3:0] op, input logic c, input logic z,
                              input logic l);
    exp_t e;
    e.a = a; e.b = b; e.data = d; e.op = op; e.carry = c; e.dz = z; e.last = l;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: pops one expectation per response handshake and checks holds.
  initial begin
    logic [34:0] snap;
    logic        hold;
    exp_t        e;
    hold = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold)
          check("hold_stable", 64'({rsp_data, rsp_op, rsp_carry, rsp_dz, rsp_last,
                                    alu_a, alu_b, alu_sel}), 64'(snap));
        if (rsp_valid) check("busy_cmd_ready", 64'(cmd_ready), 64'd0);
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp_op", 64'(rsp_op), 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            check("rsp_data", 64'(rsp_data), 64'(e.data));
            check("rsp_op", 64'(rsp_op), 64'(e.op));
            check("rsp_carry", 64'(rsp_carry), 64'(e.carry));
            check("rsp_dz", 64'(rsp_dz), 64'(e.dz));
            check("rsp_last", 64'(rsp_last), 64'(e.last));
            check("alu_operands", 64'({alu_a, alu_b, alu_sel}), 64'({e.a, e.b, e.op}));
          end
          resp_idx++;
        end
        hold = rsp_valid && !rsp_ready;
        snap = {rsp_data, rsp_op, rsp_carry, rsp_dz, rsp_last, alu_a, alu_b, alu_sel};
      end
    end
  end

  // Response-side back-pressure.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (rsp_valid && resp_idx == 2 && stall_cnt < 5) begin
            rsp_ready = 1'b0;
            stall_cnt++;
          end else begin
            rsp_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Offer a command and check the accept-to-valid latency; optionally push
  // the model's expectations for it.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      input logic sw, input logic use_model);
    int guard;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) check("accept_wait", 64'(cmd_ready), 64'd1);
    if (use_model) begin
      if (sw) for (int i = 0; i < 16; i++) exp_q.push_back(model(a, b, 4'(i), i == 15));
      else exp_q.push_back(model(a, b, op, 1'b1));
    end
    resp_idx  = 0;
    stall_cnt = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_sweep = sw; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 4'($urandom);
    cmd_sweep = 1'($urandom);
    check("exec_cmd_ready", 64'(cmd_ready), 64'd0);
    check("exec_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    check("latency_rsp_valid", 64'(rsp_valid), 64'd1);
  endtask

  // Wait until every expected response has been seen, optionally offering
  // junk commands that must be ignored.
  task automatic drain(input logic inject);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      if (inject) begin
        cmd_valid = 1'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
        cmd_op = 4'($urandom); cmd_sweep = 1'($urandom);
      end
      @(posedge clk);
      #1;
      guard++;
    end
    cmd_valid = 1'b0;
    if (guard >= 2000) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_fields"}, 64'({rsp_data, rsp_op, rsp_carry, rsp_dz, rsp_last}), 64'd0);
    check({tag, "_alu_outputs"}, 64'({alu_a, alu_b, alu_sel}), 64'd0);
  endtask

  initial begin
    logic [7:0] sweep_tbl [16];
    logic [7:0] ra;
    logic [7:0] rb;
    int         guard;
    sweep_tbl = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                  8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = 8'd0; cmd_b = 8'd0; cmd_op = 4'd0; cmd_sweep = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Directed single ops with fixed expected values.
    exp_q.push_back(mk(8'h0A, 8'h02, 8'h0C, OpAdd, 1'b0, 1'b0, 1'b1));
    send(8'h0A, 8'h02, OpAdd, 1'b0, 1'b0);
    drain(1'b0);
    exp_q.push_back(mk(8'hF6, 8'h0A, 8'h00, OpAdd, 1'b1, 1'b0, 1'b1));
    send(8'hF6, 8'h0A, OpAdd, 1'b0, 1'b0);
    drain(1'b0);
    exp_q.push_back(mk(8'hF6, 8'h0A, 8'h01, OpGt, 1'b0, 1'b0, 1'b1));
    send(8'hF6, 8'h0A, OpGt, 1'b0, 1'b0);
    drain(1'b0);
    exp_q.push_back(mk(8'h0A, 8'h00, 8'hFF, OpDiv, 1'b0, 1'b1, 1'b1));
    send(8'h0A, 8'h00, OpDiv, 1'b0, 1'b0);
    drain(1'b0);

    // Directed sweep against the fixed table.
    for (int i = 0; i < 16; i++)
      exp_q.push_back(mk(8'h0A, 8'h02, sweep_tbl[i], 4'(i), 1'b0, 1'b0, i == 15));
    send(8'h0A, 8'h02, OpAdd, 1'b1, 1'b0);
    drain(1'b0);

    // Sweep with a 5-cycle stall on the third response and junk commands.
    ready_mode = 2;
    send(8'($urandom), 8'($urandom), 4'($urandom), 1'b1, 1'b1);
    drain(1'b1);
    check("stall_cycles", 64'(stall_cnt), 64'd5);
    ready_mode = 0;

    // Randomised commands under random back-pressure.
    for (int n = 0; n < 40; n++) begin
      ready_mode = ($urandom_range(0, 1) == 0) ? 0 : 1;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      send(ra, rb, 4'($urandom), ($urandom_range(0, 4) == 0), 1'b1);
      drain(1'b1);
    end
    ready_mode = 0;

    // Reset after the seventh response of a sweep.
    send(8'($urandom), 8'($urandom), 4'd0, 1'b1, 1'b1);
    guard = 0;
    while (resp_idx < 7 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("sweep_reached_rsp7", 64'(resp_idx), 64'd7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check_reset_values("midsweep_reset");
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_quiet", 64'(rsp_valid), 64'd0);
    send(8'h0A, 8'h02, OpXor, 1'b0, 1'b1);
    drain(1'b0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
